// File: rtl/prirv32_ifu_prefetch.sv
// priRV32 prefetching instruction fetch unit.
// Issues sequential word fetches under a credit limit and takes in-order responses.
// Decodes imm/rs1/rs2/rd as each word is written and buffers the result in a DEPTH-entry
// FIFO that feeds decode/execute. A redirect flushes the FIFO and marks every in-flight
// response as stale so it is dropped when it returns.
module prirv32_ifu_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_imm,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [4:0]  dec_rd,
    output logic        dec_illegal
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    // Immediate for the RV32I formats; anything without one (or illegal) yields 0.
    function automatic logic [31:0] decode_imm(input logic [31:0] w);
        logic [31:0] imm;
        logic [31:0] i_imm;
        imm   = '0;
        i_imm = {{20{w[31]}}, w[31:20]};
        case (w[6:0])
            OP_JAL:           imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            OP_LUI, OP_AUIPC: imm = {w[31:12], 12'b0};
            OP_JALR:          imm = (w[14:12] == 3'b000) ? i_imm : '0;
            OP_LOAD, OP_IMM:  imm = i_imm;
            OP_MISC:          imm = (w[14:12] == 3'b001) ? i_imm : '0; // FENCE.I only
            OP_BRANCH:        imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            OP_STORE:         imm = {{20{w[31]}}, w[31:25], w[11:7]};
            default:          imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP, OP_MISC, OP_SYSTEM: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    entry_t        fifo_q [DEPTH];

    logic [CW-1:0] live;
    logic [CW:0]   credit_sum;
    logic          req_fire;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    entry_t        push_entry;
    entry_t        head;

    // Credits: buffered entries plus live (non-stale) requests must leave room in the FIFO,
    // so every response that will be kept is guaranteed a slot.
    assign live          = outstanding - discard;
    assign credit_sum    = {1'b0, count} + {1'b0, live};
    assign mem_req_valid = rst_n && !redirect_valid && (credit_sum < DEPTH_W);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response only retires a credit if one is outstanding; guards against underflow.
    assign rsp_ok = mem_rsp_valid && (outstanding != '0);
    assign push   = mem_rsp_valid && (discard == '0) && !redirect_valid;
    assign pop    = dec_valid && dec_ready && !redirect_valid;

    // Decode the returning word so the FIFO head is ready without any comb path from memory.
    always_comb begin
        push_entry         = '0;
        push_entry.pc      = resp_pc;
        push_entry.instr   = mem_rsp_data;
        push_entry.imm     = decode_imm(mem_rsp_data);
        push_entry.rs1     = mem_rsp_data[19:15];
        push_entry.rs2     = mem_rsp_data[24:20];
        push_entry.rd      = mem_rsp_data[11:7];
        push_entry.illegal = !is_legal(mem_rsp_data[6:0]);
    end

    // Fetch/response PCs, credit counters and FIFO pointers; redirect overrides everything.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            resp_pc     <= {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this cycle's response belongs to the old stream.
            outstanding <= outstanding - CW'(rsp_ok);
            discard     <= outstanding - CW'(rsp_ok);
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
            if (mem_rsp_valid && (discard != '0))
                discard <= discard - CW'(1);
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; entries are zeroed on reset so the idle outputs read as 0.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr] <= push_entry;
        end
    end

    assign head        = fifo_q[rd_ptr];
    assign dec_valid   = (count != '0);
    assign dec_pc      = head.pc;
    assign dec_instr   = head.instr;
    assign dec_imm     = head.imm;
    assign dec_rs1     = head.rs1;
    assign dec_rs2     = head.rs2;
    assign dec_rd      = head.rd;
    assign dec_illegal = head.illegal;

    // Credit invariants: no push into a full FIFO without a pop, counters bounded by DEPTH.
    always_ff @(posedge clk_in) begin
        if (rst_n) begin
            assert (!(push && !pop && (count == FULL_CNT)));
            assert (outstanding <= FULL_CNT);
            assert (discard <= outstanding);
        end
    end

endmodule

// File: tb/tb_prirv32_ifu_prefetch.sv
// Bench for prirv32_ifu_prefetch: a queue-based memory and a stream model predict the
// request channel and FIFO head every cycle; literal checks pin the key scenarios.
module tb_prirv32_ifu_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc, dec_instr, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_illegal;

    prirv32_ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .dec_imm(dec_imm), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_illegal(dec_illegal)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [31:0] addr; int due; bit stale; } memreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    memreq_t     mq[$];      // requests accepted by memory, in order
    ent_t        eq[$];      // instructions the FIFO must hold, in order
    logic [31:0] issued[$];
    logic [31:0] m_next_addr;
    int          lat, cyc, dropped;
    int          checks, errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h000: return 32'h00500093;
            32'h004: return 32'hFE208EE3;
            32'h008: return 32'h00112623;
            32'h00C: return 32'h123450B7;
            32'h010: return 32'hFFFFFFFF;
            32'h020: return 32'h0000000B;
            32'h100: return 32'h008000EF;
            32'h104: return 32'hFE010113;
            32'h108: return 32'h0000A503;
            32'h10C: return 32'h00000073;
            32'h300: return 32'h00000517;
            32'h304: return 32'h00100F67;
            default: return {a[13:2], 5'd3, 3'd0, a[6:2], 7'h13};
        endcase
    endfunction

    function automatic bit ref_legal(input logic [31:0] w);
        int op;
        op = int'(w & 32'h7F);
        return op == 'h37 || op == 'h17 || op == 'h6F || op == 'h67 || op == 'h63 || op == 'h03
            || op == 'h23 || op == 'h13 || op == 'h33 || op == 'h0F || op == 'h73;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int op, f3;
        logic [31:0] sgn;
        op  = int'(w & 32'h7F);
        f3  = int'((w >> 12) & 32'h7);
        sgn = w[31] ? 32'hFFFF_FFFF : 32'h0;
        if (op == 'h6F)
            return (sgn & 32'hFFF0_0000) | (w & 32'h000F_F000) | (((w >> 20) & 32'h1) << 11)
                 | (((w >> 21) & 32'h3FF) << 1);
        if (op == 'h37 || op == 'h17)
            return w & 32'hFFFF_F000;
        if ((op == 'h67 && f3 == 0) || op == 'h03 || op == 'h13 || (op == 'h0F && f3 == 1))
            return (sgn & 32'hFFFF_F800) | ((w >> 20) & 32'h7FF);
        if (op == 'h63)
            return (sgn & 32'hFFFF_F000) | (((w >> 7) & 32'h1) << 11)
                 | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
        if (op == 'h23)
            return (sgn & 32'hFFFF_F800) | (((w >> 25) & 32'h3F) << 5) | ((w >> 7) & 32'h1F);
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: present memory response, compare DUT against model, advance model at the edge.
    task automatic cycle();
        bit          rsp, exp_rv, rfire, pfire;
        int          live;
        logic [31:0] w;
        memreq_t     r;
        rsp           = (mq.size() > 0) && (mq[0].due <= cyc);
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'h0;
        #1;
        live = 0;
        foreach (mq[i]) if (!mq[i].stale) live++;
        exp_rv = !redirect_valid && (eq.size() + live < DEPTH);
        chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", mem_req_addr, m_next_addr);
        chk("dec_valid", 32'(dec_valid), 32'(eq.size() != 0));
        if (eq.size() != 0) begin
            w = eq[0].instr;
            chk("dec_pc", dec_pc, eq[0].pc);
            chk("dec_instr", dec_instr, w);
            chk("dec_imm", dec_imm, ref_imm(w));
            chk("dec_rs1", 32'(dec_rs1), (w >> 15) & 32'h1F);
            chk("dec_rs2", 32'(dec_rs2), (w >> 20) & 32'h1F);
            chk("dec_rd", 32'(dec_rd), (w >> 7) & 32'h1F);
            chk("dec_illegal", 32'(dec_illegal), 32'(!ref_legal(w)));
        end
        rfire = exp_rv && mem_req_ready;
        pfire = (eq.size() != 0) && dec_ready;
        @(posedge clk_in);
        cyc++;
        if (redirect_valid) begin
            eq.delete();
            if (rsp) begin void'(mq.pop_front()); dropped++; end
            foreach (mq[i]) mq[i].stale = 1'b1;
            m_next_addr = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (pfire) void'(eq.pop_front());
            if (rsp) begin
                r = mq.pop_front();
                if (r.stale) dropped++;
                else eq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
            end
            if (rfire) begin
                r.addr = m_next_addr; r.due = cyc - 1 + lat; r.stale = 1'b0;
                mq.push_back(r);
                issued.push_back(m_next_addr);
                m_next_addr = m_next_addr + 32'd4;
            end
        end
        @(negedge clk_in);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!dec_valid && n < 30) begin cycle(); n++; end
        chk(name, 32'(dec_valid), 32'h1);
    endtask

    task automatic head_lit(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] imm,
                            input logic ill);
        chk("lit_pc", dec_pc, pc);
        chk("lit_instr", dec_instr, ins);
        chk("lit_imm", dec_imm, imm);
        chk("lit_illegal", 32'(dec_illegal), 32'(ill));
    endtask

    task automatic pop_one();
        dec_ready = 1'b1; cycle(); dec_ready = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        int d0;
        checks = 0; errors = 0; cyc = 0; dropped = 0; lat = 1;
        m_next_addr = RESET_PC;
        rst_n = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_imm", dec_imm, 32'h0);
        chk("rst_dec_regs", {17'h0, dec_rs1, dec_rs2, dec_rd}, 32'h0);
        chk("rst_dec_illegal", 32'(dec_illegal), 32'h0);
        @(negedge clk_in);
        rst_n = 1'b1;

        // 1: fill with 1-cycle memory, consumer stalled
        mem_req_ready = 1'b1;
        cycle(); cycle();
        chk("t1_dec_valid", 32'(dec_valid), 32'h1);
        chk("t1_dec_pc", dec_pc, 32'h0);
        repeat (6) cycle();
        chk("t1_issued_n", 32'(issued.size()), 32'd4);
        chk("t1_addr0", issued[0], 32'h0);
        chk("t1_addr1", issued[1], 32'h4);
        chk("t1_addr2", issued[2], 32'h8);
        chk("t1_addr3", issued[3], 32'hC);
        chk("t1_stall", 32'(mem_req_valid), 32'h0);

        // 2/3: decoded fields of known words
        head_lit(32'h0, 32'h00500093, 32'd5, 1'b0);
        chk("t2_rd_addi", 32'(dec_rd), 32'd1);
        pop_one();
        head_lit(32'h4, 32'hFE208EE3, 32'hFFFF_FFFC, 1'b0);
        pop_one();
        head_lit(32'h8, 32'h00112623, 32'd12, 1'b0);
        pop_one();
        head_lit(32'hC, 32'h123450B7, 32'h1234_5000, 1'b0);
        chk("t2_rd_lui", 32'(dec_rd), 32'd1);
        pop_one();
        head_lit(32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);

        // 4: redirect with three requests in flight
        dec_ready = 1'b1; mem_req_ready = 1'b0;
        repeat (8) cycle();
        mem_req_ready = 1'b1; lat = 4;
        repeat (3) cycle();
        d0 = dropped;
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect_valid = 1'b0;
        #1;
        chk("t4_flushed", 32'(dec_valid), 32'h0);
        chk("t4_req_valid", 32'(mem_req_valid), 32'h1);
        chk("t4_req_addr", mem_req_addr, 32'h100);
        wait_valid("t4_wait");
        chk("t4_first_pc", dec_pc, 32'h100);
        chk("t4_dropped", 32'(dropped - d0), 32'd3);

        // back-to-back redirects
        redirect_valid = 1'b1; redirect_pc = 32'h200; cycle();
        redirect_pc = 32'h302; cycle();
        redirect_valid = 1'b0;
        wait_valid("t4b_wait");
        chk("t4b_first_pc", dec_pc, 32'h300);

        // 5: full FIFO then simultaneous pop/push streaming, then mixed handshakes
        lat = 1; dec_ready = 1'b0;
        repeat (8) cycle();
        chk("t5_full_valid", 32'(dec_valid), 32'h1);
        dec_ready = 1'b1;
        repeat (12) cycle();
        for (int i = 0; i < 30; i++) begin
            dec_ready     = (i % 3) != 0;
            mem_req_ready = (i % 4) != 1;
            lat           = 1 + (i % 3);
            cycle();
        end
        mem_req_ready = 1'b1; lat = 1;

        // 6: asynchronous reset mid-burst
        dec_ready = 1'b0;
        repeat (4) cycle();
        #2 rst_n = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        chk("t6_dec_valid", 32'(dec_valid), 32'h0);
        chk("t6_req_valid", 32'(mem_req_valid), 32'h0);
        chk("t6_dec_pc", dec_pc, 32'h0);
        eq.delete(); mq.delete(); m_next_addr = RESET_PC;
        @(negedge clk_in);
        rst_n = 1'b1;
        #1;
        chk("t6_restart_valid", 32'(mem_req_valid), 32'h1);
        chk("t6_restart_addr", mem_req_addr, RESET_PC);
        dec_ready = 1'b1;
        repeat (12) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
